softmax_pipe_ctrl: RTL and testbench

Sequencer for the pipelined softmax datapath. It runs three passes over a vector held in the input buffer: running max, then exp-and-accumulate, then normalize and write. For each pass it drives buffer read addresses and the per-stage enables of the pipeline's 32-bit enable-gated stage registers. A valid shift register tracks stage occupancy, and output backpressure stalls the normalize pass.

---
 rtl/softmax_pipe_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_softmax_pipe_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// softmax_pipe_ctrl
//
// Sequencer for the pipelined softmax datapath. It walks the input buffer
// three times: running-max pass, exp-and-accumulate pass, and
// normalize-and-write pass. During each pass it issues buffer reads, gates the
// datapath stage registers, and tracks stage occupancy with a valid shift
// register. Output backpressure (out_ready_i low) stalls the normalize pass
// only.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   start_i      begin a run (honoured only in IDLE)
//   len_i        vector length, sampled when start is honoured (0 allowed)
//   out_ready_i  downstream can take a result (normalize pass only)
//   busy_o       run in progress (includes the DONE cycle)
//   done_o       one-cycle completion pulse
//   phase_o      0 idle/done, 1 max, 2 sum, 3 normalize
//   rd_en_o      input buffer read strobe
//   rd_addr_o    input buffer read address
//   stage_en_o   per-stage enables of the datapath stage registers
//   max_clr_o    clear the running-max register
//   max_en_o     update running max with the last-stage value
//   acc_clr_o    clear the exp-sum accumulator
//   acc_en_o     accumulate the last-stage value
//   wr_en_o      normalized result valid / write strobe
//   wr_addr_o    output write address
// ---------------------------------------------------------------------------
module softmax_pipe_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_W:0]       len_i,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            phase_o,
    output logic                  rd_en_o,
    output logic [ADDR_W-1:0]     rd_addr_o,
    output logic [PIPE_DEPTH-1:0] stage_en_o,
    output logic                  max_clr_o,
    output logic                  max_en_o,
    output logic                  acc_clr_o,
    output logic                  acc_en_o,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX_ISSUE,
        S_MAX_DRAIN,
        S_SUM_ISSUE,
        S_SUM_DRAIN,
        S_NORM_ISSUE,
        S_NORM_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t                  state_q, state_d;
    logic [ADDR_W:0]         len_q, len_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [PIPE_DEPTH-1:0]   v_q, v_d;

    logic [1:0]              phase;
    logic                    issuing;
    logic                    stall;
    logic                    rd_en;
    logic                    last_issue;
    logic [ADDR_W:0]         len_last;
    logic [PIPE_DEPTH-1:0]   v_shift;
    logic                    pipe_empty_next;
    logic                    last_valid;
    logic                    max_clr;
    logic                    acc_clr;
    logic                    wr_en;

    // ------------------------------------------------------------------
    // State decode
    // ------------------------------------------------------------------
    always_comb begin
        phase = 2'd0;
        case (state_q)
            S_MAX_ISSUE, S_MAX_DRAIN:   phase = 2'd1;
            S_SUM_ISSUE, S_SUM_DRAIN:   phase = 2'd2;
            S_NORM_ISSUE, S_NORM_DRAIN: phase = 2'd3;
            default:                    phase = 2'd0;
        endcase
    end

    assign issuing = (state_q == S_MAX_ISSUE) || (state_q == S_SUM_ISSUE) ||
                     (state_q == S_NORM_ISSUE);

    // Backpressure is combinational on the current out_ready so a result is
    // never presented on a cycle the consumer cannot take it.
    assign stall = (phase == 2'd3) && !out_ready_i;

    assign rd_en      = issuing && !stall;
    assign len_last   = len_q - LEN_ONE;
    // Compare on ADDR_W+1 bits so len = 2^ADDR_W ends at all-ones.
    assign last_issue = rd_en && ({1'b0, rd_addr_q} == len_last);

    // ------------------------------------------------------------------
    // Valid pipe and stage enables
    // ------------------------------------------------------------------
    assign v_shift[0]    = issuing;
    assign stage_en_o[0] = issuing && !stall;

    generate
        for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_stage
            assign v_shift[gi]    = v_q[gi-1];
            assign stage_en_o[gi] = v_q[gi-1] && !stall;
        end
    endgenerate

    assign v_d             = stall ? v_q : v_shift;
    assign pipe_empty_next = (v_d == '0);
    assign last_valid      = v_q[PIPE_DEPTH-1];

    assign wr_en = last_valid && (phase == 2'd3) && !stall;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        max_clr   = 1'b0;
        acc_clr   = 1'b0;

        // Address returns to 0 after the final issue, ready for the next pass.
        if (rd_en) begin
            rd_addr_d = last_issue ? '0 : rd_addr_q + ADDR_ONE;
        end
        if (wr_en) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
        end

        case (state_q)
            S_IDLE: begin
                // Gate with rst so the pulse cannot appear while held in reset.
                if (start_i && !rst) begin
                    if (len_i != '0) begin
                        len_d   = len_i;
                        max_clr = 1'b1;
                        state_d = S_MAX_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MAX_ISSUE: begin
                if (last_issue) state_d = S_MAX_DRAIN;
            end
            S_MAX_DRAIN: begin
                if (pipe_empty_next) begin
                    acc_clr = 1'b1;
                    state_d = S_SUM_ISSUE;
                end
            end
            S_SUM_ISSUE: begin
                if (last_issue) state_d = S_SUM_DRAIN;
            end
            S_SUM_DRAIN: begin
                if (pipe_empty_next) begin
                    wr_addr_d = '0;
                    state_d   = S_NORM_ISSUE;
                end
            end
            S_NORM_ISSUE: begin
                if (last_issue) state_d = S_NORM_DRAIN;
            end
            S_NORM_DRAIN: begin
                if (pipe_empty_next) state_d = S_DONE;
            end
            S_DONE: begin
                wr_addr_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            v_q       <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            v_q       <= v_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign phase_o   = phase;
    assign rd_en_o   = rd_en;
    assign rd_addr_o = rd_addr_q;
    assign max_clr_o = max_clr;
    assign max_en_o  = last_valid && (phase == 2'd1);
    assign acc_clr_o = acc_clr;
    assign acc_en_o  = last_valid && (phase == 2'd2);
    assign wr_en_o   = wr_en;
    assign wr_addr_o = wr_addr_q;

endmodule

// File: tb/tb_softmax_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_softmax_pipe_ctrl
//
// Two instances: dut_a (ADDR_W=10) for the main scenarios and dut_b
// (ADDR_W=3) for the full-length vector. Expected read/write addresses are
// queued when a run is launched and popped as the DUT strobes rd_en / wr_en.
// Cycle numbering: start is sampled at edge 0; the cycle after edge k is
// reported as cycle k+1, held in rel as k.
// ---------------------------------------------------------------------------
module tb_softmax_pipe_ctrl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, out_ready;
    logic [10:0] len_a;
    logic [3:0]  len_b;

    logic       busy_a, done_a, rd_en_a, max_clr_a, max_en_a, acc_clr_a, acc_en_a, wr_en_a;
    logic [1:0] phase_a;
    logic [9:0] rd_addr_a, wr_addr_a;
    logic [3:0] stage_en_a;

    logic       busy_b, done_b, rd_en_b, max_clr_b, max_en_b, acc_clr_b, acc_en_b, wr_en_b;
    logic [1:0] phase_b;
    logic [2:0] rd_addr_b, wr_addr_b;
    logic [3:0] stage_en_b;

    softmax_pipe_ctrl #(.ADDR_W(10), .PIPE_DEPTH(D)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .len_i(len_a), .out_ready_i(out_ready),
        .busy_o(busy_a), .done_o(done_a), .phase_o(phase_a), .rd_en_o(rd_en_a),
        .rd_addr_o(rd_addr_a), .stage_en_o(stage_en_a), .max_clr_o(max_clr_a),
        .max_en_o(max_en_a), .acc_clr_o(acc_clr_a), .acc_en_o(acc_en_a),
        .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a)
    );

    softmax_pipe_ctrl #(.ADDR_W(3), .PIPE_DEPTH(D)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .len_i(len_b), .out_ready_i(out_ready),
        .busy_o(busy_b), .done_o(done_b), .phase_o(phase_b), .rd_en_o(rd_en_b),
        .rd_addr_o(rd_addr_b), .stage_en_o(stage_en_b), .max_clr_o(max_clr_b),
        .max_en_o(max_en_b), .acc_clr_o(acc_clr_b), .acc_en_o(acc_en_b),
        .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rel;
    bit sel_b;

    int exp_rd[$];
    int exp_wr[$];

    // sampled outputs of the selected instance
    logic       s_busy, s_done, s_rd_en, s_max_clr, s_max_en, s_acc_clr, s_acc_en, s_wr_en;
    logic [1:0] s_phase;
    logic [9:0] s_rd_addr, s_wr_addr;
    logic [3:0] s_stage_en;

    // per-run statistics
    int n_max_en, n_acc_en, n_acc_clr, n_max_clr, n_done, n_stage_bits;
    int done_rel, busy_first, busy_last, max_phase, max_rd;
    int n_stall, n_stall_bad;
    bit prev_stalled;
    logic [9:0] prev_rd, prev_wr;

    task automatic clear_stats();
        n_max_en = 0; n_acc_en = 0; n_acc_clr = 0; n_max_clr = 0; n_done = 0;
        n_stage_bits = 0; done_rel = -1; busy_first = -1; busy_last = -1;
        max_phase = 0; max_rd = 0; n_stall = 0; n_stall_bad = 0; prev_stalled = 1'b0;
        prev_rd = '0; prev_wr = '0;
    endtask

    // Sample one cycle at the falling edge, score strobes, advance past the
    // next rising edge.
    task automatic tick();
        int e;
        @(negedge clk);
        if (sel_b) begin
            s_busy = busy_b; s_done = done_b; s_rd_en = rd_en_b; s_max_clr = max_clr_b;
            s_max_en = max_en_b; s_acc_clr = acc_clr_b; s_acc_en = acc_en_b; s_wr_en = wr_en_b;
            s_phase = phase_b; s_rd_addr = {7'd0, rd_addr_b}; s_wr_addr = {7'd0, wr_addr_b};
            s_stage_en = stage_en_b;
        end else begin
            s_busy = busy_a; s_done = done_a; s_rd_en = rd_en_a; s_max_clr = max_clr_a;
            s_max_en = max_en_a; s_acc_clr = acc_clr_a; s_acc_en = acc_en_a; s_wr_en = wr_en_a;
            s_phase = phase_a; s_rd_addr = rd_addr_a; s_wr_addr = wr_addr_a;
            s_stage_en = stage_en_a;
        end
        if (s_rd_en === 1'b1) begin
            checks++;
            if (int'(s_rd_addr) > max_rd) max_rd = int'(s_rd_addr);
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_extra: cycle %0d got read addr %0d, none expected", rel + 1, s_rd_addr);
            end else begin
                e = exp_rd.pop_front();
                if (s_rd_addr !== 10'(e)) begin
                    errors++;
                    $display("FAIL rd_addr: cycle %0d got %0d, expected %0d", rel + 1, s_rd_addr, e);
                end
            end
        end
        if (s_wr_en === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_extra: cycle %0d got write addr %0d, none expected", rel + 1, s_wr_addr);
            end else begin
                e = exp_wr.pop_front();
                if (s_wr_addr !== 10'(e)) begin
                    errors++;
                    $display("FAIL wr_addr: cycle %0d got %0d, expected %0d", rel + 1, s_wr_addr, e);
                end
            end
        end
        if (s_max_en === 1'b1)  n_max_en++;
        if (s_acc_en === 1'b1)  n_acc_en++;
        if (s_acc_clr === 1'b1) n_acc_clr++;
        if (s_max_clr === 1'b1) n_max_clr++;
        n_stage_bits += $countones(s_stage_en);
        if (int'(s_phase) > max_phase) max_phase = int'(s_phase);
        // a stalled cycle must gate everything and leave addresses unchanged
        if (prev_stalled && (s_rd_addr !== prev_rd || s_wr_addr !== prev_wr)) n_stall_bad++;
        prev_stalled = 1'b0;
        if (!out_ready && s_phase == 2'd3) begin
            n_stall++;
            prev_stalled = 1'b1;
            if (s_stage_en !== 4'd0 || s_rd_en !== 1'b0 || s_wr_en !== 1'b0) n_stall_bad++;
        end
        prev_rd = s_rd_addr;
        prev_wr = s_wr_addr;
        if (s_done === 1'b1) begin
            n_done++;
            done_rel = rel;
        end
        if (s_busy === 1'b1) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
        end
        @(posedge clk);
        #1;
        rel++;
    endtask

    // Launch one run, queue its expected addresses and clock it to completion.
    task automatic run_vec(input int L, input bit use_b, input int stall_at,
                           input int stall_n, input bit poke);
        int limit;
        clear_stats();
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < L; a++) exp_rd.push_back(a);
        for (int a = 0; a < L; a++) exp_wr.push_back(a);
        sel_b = use_b;
        len_a = 11'(L);
        len_b = 4'(L);
        out_ready = 1'b1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        rel = -1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        limit = 3 * (L + D) + stall_n + 6;
        while (rel <= limit) begin
            if (poke && (rel == 4 || rel == 9)) begin
                start_a = 1'b1;
                len_a   = 11'd7;
            end else begin
                start_a = 1'b0;
            end
            out_ready = !(rel >= stall_at && rel < stall_at + stall_n);
            tick();
        end
        start_a = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [33:0] outs;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; out_ready = 1'b1;
        len_a = '0; len_b = '0; sel_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs = {busy_a, done_a, phase_a, rd_en_a, rd_addr_a, stage_en_a, max_clr_a,
                max_en_a, acc_clr_a, acc_en_a, wr_en_a, wr_addr_a};
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst = 1'b0;
        clear_stats();
        rel = 0;
        repeat (3) tick();
        checks++;
        if (busy_last != -1 || n_done != 0) begin
            errors++;
            $display("FAIL reset_idle: busy_last %0d done %0d, expected -1 and 0", busy_last, n_done);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        run_vec(4, 1'b0, 1000, 0, 1'b0);
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL basic_drained: %0d reads, %0d writes left, expected 0", exp_rd.size(), exp_wr.size());
        end
        checks++;
        if (n_max_en != 4 || n_acc_en != 4) begin
            errors++;
            $display("FAIL basic_consumers: max_en %0d acc_en %0d, expected 4 4", n_max_en, n_acc_en);
        end
        checks++;
        if (n_acc_clr != 1 || n_max_clr != 1) begin
            errors++;
            $display("FAIL basic_clears: acc_clr %0d max_clr %0d, expected 1 1", n_acc_clr, n_max_clr);
        end
        checks++;
        if (n_done != 1 || done_rel + 1 != 25) begin
            errors++;
            $display("FAIL basic_done: %0d pulses at cycle %0d, expected 1 at 25", n_done, done_rel + 1);
        end
        checks++;
        if (busy_first != 0 || busy_last + 1 != 25) begin
            errors++;
            $display("FAIL basic_busy: cycles %0d..%0d, expected 1..25", busy_first + 1, busy_last + 1);
        end
        checks++;
        if (n_stage_bits != 3 * 4 * D) begin
            errors++;
            $display("FAIL basic_stage_en: %0d enables, expected %0d", n_stage_bits, 3 * 4 * D);
        end
        $display("test_basic: len=4 done at cycle %0d", done_rel + 1);
        exp_rd.delete(); exp_wr.delete();
    endtask

    task automatic test_len_zero();
        run_vec(0, 1'b0, 1000, 0, 1'b0);
        checks++;
        if (n_done != 1 || done_rel != 0) begin
            errors++;
            $display("FAIL zero_done: %0d pulses at cycle %0d, expected 1 at 1", n_done, done_rel + 1);
        end
        checks++;
        if (max_phase != 0 || n_max_en != 0 || n_acc_en != 0 || n_max_clr != 0 || n_stage_bits != 0) begin
            errors++;
            $display("FAIL zero_quiet: phase %0d max_en %0d acc_en %0d max_clr %0d stage %0d, expected all 0",
                     max_phase, n_max_en, n_acc_en, n_max_clr, n_stage_bits);
        end
        $display("test_len_zero: done at cycle %0d", done_rel + 1);
        exp_rd.delete(); exp_wr.delete();
    endtask

    task automatic test_stall();
        run_vec(4, 1'b0, 17, 3, 1'b0);
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL stall_drained: %0d writes, %0d reads left, expected 0", exp_wr.size(), exp_rd.size());
        end
        checks++;
        if (n_stall != 3 || n_stall_bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d stalled, %0d violations, expected 3 and 0", n_stall, n_stall_bad);
        end
        checks++;
        if (n_done != 1 || done_rel + 1 != 28) begin
            errors++;
            $display("FAIL stall_done: %0d pulses at cycle %0d, expected 1 at 28", n_done, done_rel + 1);
        end
        $display("test_stall: issue stall, done at cycle %0d", done_rel + 1);
        exp_rd.delete(); exp_wr.delete();
        // stall inside the normalize drain freezes the drain
        run_vec(4, 1'b0, 21, 2, 1'b0);
        checks++;
        if (exp_wr.size() != 0 || n_stall != 2 || n_stall_bad != 0) begin
            errors++;
            $display("FAIL drain_stall: %0d writes left, %0d stalled, %0d violations, expected 0 2 0",
                     exp_wr.size(), n_stall, n_stall_bad);
        end
        checks++;
        if (done_rel + 1 != 27 || n_stage_bits != 3 * 4 * D) begin
            errors++;
            $display("FAIL drain_stall_done: cycle %0d stage %0d, expected 27 and %0d",
                     done_rel + 1, n_stage_bits, 3 * 4 * D);
        end
        $display("test_stall: drain stall, done at cycle %0d", done_rel + 1);
        exp_rd.delete(); exp_wr.delete();
    endtask

    task automatic test_start_ignored();
        run_vec(4, 1'b0, 1000, 0, 1'b1);
        checks++;
        if (n_done != 1 || done_rel + 1 != 25 || n_max_clr != 1) begin
            errors++;
            $display("FAIL ignore_start: %0d pulses at cycle %0d, max_clr %0d, expected 1 at 25, 1",
                     n_done, done_rel + 1, n_max_clr);
        end
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0 || n_max_en != 4) begin
            errors++;
            $display("FAIL ignore_len: %0d reads %0d writes left, max_en %0d, expected 0 0 4",
                     exp_rd.size(), exp_wr.size(), n_max_en);
        end
        $display("test_start_ignored: done at cycle %0d", done_rel + 1);
        exp_rd.delete(); exp_wr.delete();
        len_a = '0;
    endtask

    task automatic test_reset_midrun();
        logic [33:0] outs;
        clear_stats();
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 4; a++) exp_rd.push_back(a);
        sel_b = 1'b0;
        len_a = 11'd4;
        start_a = 1'b1;
        rel = -1;
        tick();
        start_a = 1'b0;
        while (rel < 10) tick();
        checks++;
        if (s_phase !== 2'd2 || s_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL midrun_phase: phase %0d rd_en %b, expected 2 1", s_phase, s_rd_en);
        end
        #2;
        rst = 1'b1;
        #1;
        outs = {busy_a, done_a, phase_a, rd_en_a, rd_addr_a, stage_en_a, max_clr_a,
                max_en_a, acc_clr_a, acc_en_a, wr_en_a, wr_addr_a};
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL midrun_async: got %h, expected 0", outs);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rd.delete(); exp_wr.delete();
        clear_stats();
        rel = 0;
        repeat (30) tick();
        checks++;
        if (n_done != 0 || busy_last != -1 || n_stage_bits != 0) begin
            errors++;
            $display("FAIL midrun_quiet: done %0d busy_last %0d stage %0d, expected 0 -1 0",
                     n_done, busy_last, n_stage_bits);
        end
        run_vec(4, 1'b0, 1000, 0, 1'b0);
        checks++;
        if (n_done != 1 || done_rel + 1 != 25 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL midrun_restart: %0d pulses at cycle %0d, %0d writes left, expected 1 at 25, 0",
                     n_done, done_rel + 1, exp_wr.size());
        end
        $display("test_reset_midrun: restart done at cycle %0d", done_rel + 1);
        exp_rd.delete(); exp_wr.delete();
    endtask

    task automatic test_full_len();
        run_vec(8, 1'b1, 1000, 0, 1'b0);
        checks++;
        if (max_rd != 7 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL full_rd: max addr %0d, %0d reads left, expected 7 0", max_rd, exp_rd.size());
        end
        checks++;
        if (exp_wr.size() != 0 || n_acc_en != 8) begin
            errors++;
            $display("FAIL full_wr: %0d writes left, acc_en %0d, expected 0 8", exp_wr.size(), n_acc_en);
        end
        checks++;
        if (n_done != 1 || done_rel + 1 != 37) begin
            errors++;
            $display("FAIL full_done: %0d pulses at cycle %0d, expected 1 at 37", n_done, done_rel + 1);
        end
        $display("test_full_len: len=8 done at cycle %0d", done_rel + 1);
        exp_rd.delete(); exp_wr.delete();
        sel_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_stall();
        test_start_ignored();
        test_reset_midrun();
        test_full_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
